// File: rtl/tia_missile_control_pkg.sv
// Shared definitions for the TIA missile controller: write addresses,
// sequencer state encoding and the HMOVE motion-count helper.
package tia_missile_control_pkg;

    localparam logic [5:0] ADDR_NUSIZ0 = 6'h04;
    localparam logic [5:0] ADDR_ENAM0  = 6'h1D;
    localparam logic [5:0] ADDR_RESM0  = 6'h12;
    localparam logic [5:0] ADDR_HMM0   = 6'h22;
    localparam logic [5:0] ADDR_RESMP0 = 6'h28;
    localparam logic [5:0] ADDR_HMOVE  = 6'h2A;
    localparam logic [5:0] ADDR_HMCLR  = 6'h2B;

    localparam logic [3:0] HM_BIAS = 4'h8;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_ACTIVE
    } seq_state_t;

    // Signed motion value (-8..7) to the number of extra clocks (0..15).
    function automatic logic [3:0] hm_to_n(input logic [3:0] hm);
        return hm ^ HM_BIAS;
    endfunction

endpackage

// File: rtl/tia_hmove_sequencer.sv
// HMOVE sequencer: counts 16 motion ticks after a start strobe and emits a
// one-clock active-low pulse on each tick whose index is below n.
module tia_hmove_sequencer
    import tia_missile_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset_bar,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] n,
    output logic       pulse_bar
);

    seq_state_t state_q, state_d;
    logic [3:0] k_q, k_d;
    logic       pulse_bar_q, pulse_bar_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        k_d         = k_q;
        pulse_bar_d = 1'b1;
        if (start) begin
            // A start strobe outranks a coincident tick: restart without a pulse.
            state_d = SEQ_ACTIVE;
            k_d     = 4'd0;
        end else if (state_q == SEQ_ACTIVE && tick) begin
            pulse_bar_d = ~(k_q < n);
            k_d         = k_q + 4'd1;
            if (k_q == 4'd15) begin
                state_d = SEQ_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_bar) begin
            state_q     <= SEQ_IDLE;
            k_q         <= 4'd0;
            pulse_bar_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            pulse_bar_q <= pulse_bar_d;
        end
    end

    assign pulse_bar = pulse_bar_q;

endmodule

// File: rtl/tia_missile_control.sv
// Missile register front end: decodes TIA writes for one missile, holds its
// NUSIZ/ENAM/RESMP/HMM state and drives the HMOVE sequencer.
module tia_missile_control
    import tia_missile_control_pkg::*;
#(
    parameter int INDEX = 0
) (
    input  logic       clk,
    input  logic       reset_bar,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       hmove_tick,
    output logic       mec_bar,
    output logic       nz0_bar,
    output logic       nz1_bar,
    output logic       nz2_bar,
    output logic       nz4_bar,
    output logic       nz5_bar,
    output logic       missile_enable,
    output logic       missile_reset,
    output logic       missile_to_player_reset,
    output logic       missile_to_player_reset_bar
);

    localparam logic [5:0] A_NUSIZ = ADDR_NUSIZ0 + 6'(INDEX);
    localparam logic [5:0] A_ENAM  = ADDR_ENAM0  + 6'(INDEX);
    localparam logic [5:0] A_RESM  = ADDR_RESM0  + 6'(INDEX);
    localparam logic [5:0] A_HMM   = ADDR_HMM0   + 6'(INDEX);
    localparam logic [5:0] A_RESMP = ADDR_RESMP0 + 6'(INDEX);

    logic [2:0] copies_q, copies_d;
    logic [1:0] size_q, size_d;
    logic       enam_q, enam_d;
    logic       resm_q, resm_d;
    logic       resmp_q, resmp_d;
    logic [3:0] hm_q, hm_d;
    logic       hmove_start;

    // NUSIZ bit 3 has no meaning for a missile.
    logic unused_wr_data;
    assign unused_wr_data = wr_data[3];

    always_comb begin
        copies_d    = copies_q;
        size_d      = size_q;
        enam_d      = enam_q;
        resm_d      = 1'b0;
        resmp_d     = resmp_q;
        hm_d        = hm_q;
        hmove_start = 1'b0;
        if (wr_en) begin
            unique case (wr_addr)
                A_NUSIZ: begin
                    copies_d = wr_data[2:0];
                    size_d   = wr_data[5:4];
                end
                A_ENAM:     enam_d      = wr_data[1];
                A_RESM:     resm_d      = 1'b1;
                A_HMM:      hm_d        = wr_data[7:4];
                A_RESMP:    resmp_d     = wr_data[1];
                ADDR_HMOVE: hmove_start = 1'b1;
                ADDR_HMCLR: hm_d        = 4'd0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            copies_q <= 3'd0;
            size_q   <= 2'd0;
            enam_q   <= 1'b0;
            resm_q   <= 1'b0;
            resmp_q  <= 1'b0;
            hm_q     <= 4'd0;
        end else begin
            copies_q <= copies_d;
            size_q   <= size_d;
            enam_q   <= enam_d;
            resm_q   <= resm_d;
            resmp_q  <= resmp_d;
            hm_q     <= hm_d;
        end
    end

    tia_hmove_sequencer u_seq (
        .clk       (clk),
        .reset_bar (reset_bar),
        .start     (hmove_start),
        .tick      (hmove_tick),
        .n         (hm_to_n(hm_q)),
        .pulse_bar (mec_bar)
    );

    assign nz0_bar                     = ~copies_q[0];
    assign nz1_bar                     = ~copies_q[1];
    assign nz2_bar                     = ~copies_q[2];
    assign nz4_bar                     = ~size_q[0];
    assign nz5_bar                     = ~size_q[1];
    assign missile_enable              = enam_q;
    assign missile_reset               = resm_q;
    assign missile_to_player_reset     = resmp_q;
    assign missile_to_player_reset_bar = ~resmp_q;

endmodule
